mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares one tagged memory port (request command, request data, response) between two sources, e.g. the core's uncached memory channel and the backup-memory path. Requests are granted round-robin and tagged with the requester index in the extra MSB of the outgoing tag. Write commands lock the grant until all data beats have been forwarded. Responses are steered back by that MSB.

---
 rtl/mem_port_arbiter_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Tagged memory port bundle: command, write data and response channels.
// The requester drives the master side and the memory drives the slave side.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_BITS = 26,
    parameter int unsigned TAG_BITS  = 5,
    parameter int unsigned DATA_BITS = 128
) ();

    logic                 req_cmd_valid;
    logic                 req_cmd_ready;
    logic                 req_cmd_bits_rw;
    logic [ADDR_BITS-1:0] req_cmd_bits_addr;
    logic [TAG_BITS-1:0]  req_cmd_bits_tag;

    logic                 req_data_valid;
    logic                 req_data_ready;
    logic [DATA_BITS-1:0] req_data_bits_data;

    logic                 resp_valid;
    logic                 resp_ready;
    logic [TAG_BITS-1:0]  resp_bits_tag;
    logic [DATA_BITS-1:0] resp_bits_data;

    modport master (
        output req_cmd_valid, req_cmd_bits_rw, req_cmd_bits_addr, req_cmd_bits_tag,
        output req_data_valid, req_data_bits_data,
        output resp_ready,
        input  req_cmd_ready, req_data_ready,
        input  resp_valid, resp_bits_tag, resp_bits_data
    );

    modport slave (
        input  req_cmd_valid, req_cmd_bits_rw, req_cmd_bits_addr, req_cmd_bits_tag,
        input  req_data_valid, req_data_bits_data,
        input  resp_ready,
        output req_cmd_ready, req_data_ready,
        output resp_valid, resp_bits_tag, resp_bits_data
    );

endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one tagged memory port between two requesters.
// Writes lock the data channel to their owner; responses route by the tag MSB.
module mem_port_arbiter #(
    parameter int unsigned ADDR_BITS  = 26,
    parameter int unsigned TAG_BITS   = 5,
    parameter int unsigned DATA_BITS  = 128,
    parameter int unsigned DATA_BEATS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_port_arbiter_if.slave     io_in0,
    mem_port_arbiter_if.slave     io_in1,
    mem_port_arbiter_if.master    io_out
);

    localparam int unsigned BEAT_W = (DATA_BEATS > 1) ? $clog2(DATA_BEATS) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        WDATA = 1'b1
    } state_t;

    state_t              state;
    logic                prio;
    logic                hold;
    logic                hold_id;
    logic                owner;
    logic [BEAT_W-1:0]   beat;

    logic                grant_c;
    logic                cmd_open_c;
    logic                cmd_valid_c;
    logic                cmd_fire_c;
    logic                data_open_c;
    logic                data_valid_c;
    logic                data_fire_c;
    logic                last_beat_c;
    logic                resp_dst_c;
    logic                sel_rw_c;
    logic [ADDR_BITS-1:0] sel_addr_c;
    logic [TAG_BITS-1:0]  sel_tag_c;
    logic [DATA_BITS-1:0] sel_data_c;

    // Grant: a stalled command keeps its grant; otherwise round-robin on contention.
    always_comb begin
        grant_c = 1'b0;
        if (hold) begin
            grant_c = hold_id;
        end else if (io_in0.req_cmd_valid && io_in1.req_cmd_valid) begin
            grant_c = prio;
        end else if (io_in1.req_cmd_valid) begin
            grant_c = 1'b1;
        end
    end

    // Command channel, open only in IDLE and never during reset.
    assign cmd_open_c  = !reset && (state == IDLE);
    assign cmd_valid_c = cmd_open_c &&
                         (grant_c ? io_in1.req_cmd_valid : io_in0.req_cmd_valid);
    assign cmd_fire_c  = cmd_valid_c && io_out.req_cmd_ready;

    assign sel_rw_c   = grant_c ? io_in1.req_cmd_bits_rw   : io_in0.req_cmd_bits_rw;
    assign sel_addr_c = grant_c ? io_in1.req_cmd_bits_addr : io_in0.req_cmd_bits_addr;
    assign sel_tag_c  = grant_c ? io_in1.req_cmd_bits_tag  : io_in0.req_cmd_bits_tag;

    assign io_out.req_cmd_valid     = cmd_valid_c;
    assign io_out.req_cmd_bits_rw   = sel_rw_c;
    assign io_out.req_cmd_bits_addr = sel_addr_c;
    assign io_out.req_cmd_bits_tag  = {grant_c, sel_tag_c};
    assign io_in0.req_cmd_ready     = cmd_open_c && !grant_c && io_out.req_cmd_ready;
    assign io_in1.req_cmd_ready     = cmd_open_c &&  grant_c && io_out.req_cmd_ready;

    // Write-data channel, owned by the requester whose write command fired.
    assign data_open_c  = !reset && (state == WDATA);
    assign data_valid_c = data_open_c &&
                          (owner ? io_in1.req_data_valid : io_in0.req_data_valid);
    assign data_fire_c  = data_valid_c && io_out.req_data_ready;
    assign last_beat_c  = (beat == BEAT_W'(DATA_BEATS - 1));
    assign sel_data_c   = owner ? io_in1.req_data_bits_data : io_in0.req_data_bits_data;

    assign io_out.req_data_valid     = data_valid_c;
    assign io_out.req_data_bits_data = sel_data_c;
    assign io_in0.req_data_ready     = data_open_c && !owner && io_out.req_data_ready;
    assign io_in1.req_data_ready     = data_open_c &&  owner && io_out.req_data_ready;

    // Response steering by the tag MSB; independent of arbitration state.
    assign resp_dst_c = io_out.resp_bits_tag[TAG_BITS];

    assign io_in0.resp_valid     = !reset && io_out.resp_valid && !resp_dst_c;
    assign io_in1.resp_valid     = !reset && io_out.resp_valid &&  resp_dst_c;
    assign io_in0.resp_bits_tag  = io_out.resp_bits_tag[TAG_BITS-1:0];
    assign io_in1.resp_bits_tag  = io_out.resp_bits_tag[TAG_BITS-1:0];
    assign io_in0.resp_bits_data = io_out.resp_bits_data;
    assign io_in1.resp_bits_data = io_out.resp_bits_data;
    assign io_out.resp_ready     = !reset &&
                                   (resp_dst_c ? io_in1.resp_ready : io_in0.resp_ready);

    // Arbitration and write-burst state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            prio    <= 1'b0;
            hold    <= 1'b0;
            hold_id <= 1'b0;
            owner   <= 1'b0;
            beat    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_fire_c) begin
                        prio <= ~grant_c;
                        hold <= 1'b0;
                        if (sel_rw_c) begin
                            state <= WDATA;
                            owner <= grant_c;
                            beat  <= '0;
                        end
                    end else if (cmd_valid_c) begin
                        hold    <= 1'b1;
                        hold_id <= grant_c;
                    end
                end
                WDATA: begin
                    if (data_fire_c) begin
                        if (last_beat_c) begin
                            state <= IDLE;
                            beat  <= '0;
                        end else begin
                            beat <= beat + BEAT_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expectations,
// a negedge monitor pops and compares on every forwarded command, beat and response.
module tb_mem_port_arbiter;

    localparam int unsigned AB = 26;
    localparam int unsigned TB = 5;
    localparam int unsigned DB = 128;
    localparam int unsigned NB = 4;

    logic clk = 1'b0;
    logic reset;

    mem_port_arbiter_if #(.ADDR_BITS(AB), .TAG_BITS(TB),     .DATA_BITS(DB)) in0_if ();
    mem_port_arbiter_if #(.ADDR_BITS(AB), .TAG_BITS(TB),     .DATA_BITS(DB)) in1_if ();
    mem_port_arbiter_if #(.ADDR_BITS(AB), .TAG_BITS(TB + 1), .DATA_BITS(DB)) out_if ();

    mem_port_arbiter #(
        .ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BITS(DB), .DATA_BEATS(NB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .io_in0 (in0_if),
        .io_in1 (in1_if),
        .io_out (out_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          rw;
        logic [AB-1:0] addr;
        logic [TB:0]   tag;
    } cmd_t;

    typedef struct packed {
        logic [TB-1:0] tag;
        logic [DB-1:0] data;
    } resp_t;

    cmd_t          exp_cmd[$];
    logic [DB-1:0] exp_data[$];
    resp_t         exp_r0[$];
    resp_t         exp_r1[$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DB-1:0] beat_val(input int r, input int k);
        logic [31:0] w;
        w = 32'hB0B0_0000 + 32'(r * 16 + k);
        return {4{w}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every handshake on a DUT-driven channel must match the head of its queue.
    always @(negedge clk) begin
        cmd_t  got_c;
        resp_t got_r;
        if (out_if.req_cmd_valid && out_if.req_cmd_ready) begin
            got_c = {out_if.req_cmd_bits_rw, out_if.req_cmd_bits_addr, out_if.req_cmd_bits_tag};
            if (exp_cmd.size() == 0) check("cmd_unexpected", 160'(got_c), 160'(0));
            else check("out_cmd", 160'(got_c), 160'(exp_cmd.pop_front()));
        end
        if (out_if.req_data_valid && out_if.req_data_ready) begin
            if (exp_data.size() == 0) check("data_unexpected", 160'(out_if.req_data_bits_data), 160'(0));
            else check("out_data", 160'(out_if.req_data_bits_data), 160'(exp_data.pop_front()));
        end
        if (in0_if.resp_valid && in0_if.resp_ready) begin
            got_r = {in0_if.resp_bits_tag, in0_if.resp_bits_data};
            if (exp_r0.size() == 0) check("resp0_unexpected", 160'(got_r), 160'(0));
            else check("in0_resp", 160'(got_r), 160'(exp_r0.pop_front()));
        end
        if (in1_if.resp_valid && in1_if.resp_ready) begin
            got_r = {in1_if.resp_bits_tag, in1_if.resp_bits_data};
            if (exp_r1.size() == 0) check("resp1_unexpected", 160'(got_r), 160'(0));
            else check("in1_resp", 160'(got_r), 160'(exp_r1.pop_front()));
        end
    end

    initial begin
        #60000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        logic f0, f1, c0f, c1f, df, cmd_done;
        int   j0, j1, beats, last_cyc, r0_cyc;

        // Reset with activity on every input: all valid/ready outputs must stay low.
        reset = 1'b1;
        in0_if.req_cmd_valid = 1'b1; in0_if.req_cmd_bits_rw = 1'b0;
        in0_if.req_cmd_bits_addr = '0; in0_if.req_cmd_bits_tag = '0;
        in1_if.req_cmd_valid = 1'b0; in1_if.req_cmd_bits_rw = 1'b0;
        in1_if.req_cmd_bits_addr = '0; in1_if.req_cmd_bits_tag = '0;
        in0_if.req_data_valid = 1'b1; in0_if.req_data_bits_data = '0;
        in1_if.req_data_valid = 1'b0; in1_if.req_data_bits_data = '0;
        in0_if.resp_ready = 1'b1; in1_if.resp_ready = 1'b1;
        out_if.req_cmd_ready = 1'b1; out_if.req_data_ready = 1'b1;
        out_if.resp_valid = 1'b1; out_if.resp_bits_tag = '0; out_if.resp_bits_data = '0;
        repeat (2) tick();
        @(negedge clk);
        check("rst_out_cmd_valid",  160'(out_if.req_cmd_valid), 160'(0));
        check("rst_in0_cmd_ready",  160'(in0_if.req_cmd_ready), 160'(0));
        check("rst_in0_data_ready", 160'(in0_if.req_data_ready), 160'(0));
        check("rst_in0_resp_valid", 160'(in0_if.resp_valid), 160'(0));
        check("rst_out_resp_ready", 160'(out_if.resp_ready), 160'(0));
        tick();
        reset = 1'b0;
        in0_if.req_cmd_valid = 1'b0;
        out_if.resp_valid = 1'b0;

        // Data offered in IDLE without a command is held back.
        @(negedge clk);
        check("idle_out_data_valid", 160'(out_if.req_data_valid), 160'(0));
        check("idle_in0_data_ready", 160'(in0_if.req_data_ready), 160'(0));
        tick();
        in0_if.req_data_valid = 1'b0;

        // Back-to-back reads from both requesters alternate 0,1,0,1.
        exp_cmd.push_back('{rw: 1'b0, addr: 26'h100, tag: 6'h00});
        exp_cmd.push_back('{rw: 1'b0, addr: 26'h200, tag: 6'h30});
        exp_cmd.push_back('{rw: 1'b0, addr: 26'h101, tag: 6'h01});
        exp_cmd.push_back('{rw: 1'b0, addr: 26'h201, tag: 6'h31});
        j0 = 0; j1 = 0;
        in0_if.req_cmd_valid = 1'b1; in0_if.req_cmd_bits_addr = 26'h100; in0_if.req_cmd_bits_tag = 5'h00;
        in1_if.req_cmd_valid = 1'b1; in1_if.req_cmd_bits_addr = 26'h200; in1_if.req_cmd_bits_tag = 5'h10;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            f0 = in0_if.req_cmd_valid && in0_if.req_cmd_ready;
            f1 = in1_if.req_cmd_valid && in1_if.req_cmd_ready;
            check("rr_grant", 160'({f0, f1}), 160'((k % 2 == 0) ? 2'b10 : 2'b01));
            tick();
            if (f0) begin j0++; in0_if.req_cmd_bits_addr = 26'(26'h100 + j0); in0_if.req_cmd_bits_tag = 5'(j0); end
            if (f1) begin j1++; in1_if.req_cmd_bits_addr = 26'(26'h200 + j1); in1_if.req_cmd_bits_tag = 5'(5'h10 + j1); end
        end
        in0_if.req_cmd_valid = 1'b0;
        in1_if.req_cmd_valid = 1'b0;

        // Lone read from requester 0 leaves prio pointing at requester 1.
        exp_cmd.push_back('{rw: 1'b0, addr: 26'h150, tag: 6'h06});
        in0_if.req_cmd_valid = 1'b1; in0_if.req_cmd_bits_addr = 26'h150; in0_if.req_cmd_bits_tag = 5'h06;
        @(negedge clk);
        check("lone_read_ready", 160'(in0_if.req_cmd_ready), 160'(1));
        tick();

        // Stalled command from requester 0 keeps the grant despite prio=1.
        exp_cmd.push_back('{rw: 1'b0, addr: 26'h160, tag: 6'h07});
        exp_cmd.push_back('{rw: 1'b0, addr: 26'h260, tag: 6'h29});
        out_if.req_cmd_ready = 1'b0;
        in0_if.req_cmd_bits_addr = 26'h160; in0_if.req_cmd_bits_tag = 5'h07;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_out_tag", 160'(out_if.req_cmd_bits_tag), 160'(6'h07));
            check("stall_in1_ready", 160'(in1_if.req_cmd_ready), 160'(0));
            tick();
            if (k == 0) begin
                in1_if.req_cmd_valid = 1'b1; in1_if.req_cmd_bits_addr = 26'h260; in1_if.req_cmd_bits_tag = 5'h09;
            end
        end
        out_if.req_cmd_ready = 1'b1;
        @(negedge clk);
        check("stall_release_in0", 160'(in0_if.req_cmd_ready), 160'(1));
        tick();
        in0_if.req_cmd_valid = 1'b0;
        @(negedge clk);
        check("stall_then_in1", 160'(in1_if.req_cmd_ready), 160'(1));
        tick();
        in1_if.req_cmd_valid = 1'b0;

        // Requester 1 write with toggling data ready; requester 0 waits for the burst.
        exp_cmd.push_back('{rw: 1'b1, addr: 26'h3A0, tag: 6'h22});
        for (int k = 0; k < int'(NB); k++) exp_data.push_back(beat_val(1, k));
        exp_cmd.push_back('{rw: 1'b0, addr: 26'h170, tag: 6'h0B});
        in1_if.req_cmd_valid = 1'b1; in1_if.req_cmd_bits_rw = 1'b1;
        in1_if.req_cmd_bits_addr = 26'h3A0; in1_if.req_cmd_bits_tag = 5'h02;
        in1_if.req_data_valid = 1'b1; in1_if.req_data_bits_data = beat_val(1, 0);
        out_if.req_data_ready = 1'b1;
        cmd_done = 1'b0; beats = 0; last_cyc = -1; r0_cyc = -1;
        for (int cyc = 0; cyc < 30 && r0_cyc < 0; cyc++) begin
            @(negedge clk);
            c1f = in1_if.req_cmd_valid && in1_if.req_cmd_ready;
            df  = in1_if.req_data_valid && in1_if.req_data_ready;
            c0f = in0_if.req_cmd_valid && in0_if.req_cmd_ready;
            if (c1f) check("no_data_on_cmd_cycle", 160'(out_if.req_data_valid), 160'(0));
            if (cmd_done && beats < int'(NB))
                check("wdata_blocks_cmd", 160'({in0_if.req_cmd_ready, out_if.req_cmd_valid}), 160'(0));
            if (df) begin
                beats++;
                if (beats == int'(NB)) last_cyc = cyc;
            end
            if (c0f) r0_cyc = cyc;
            tick();
            if (c1f) begin
                in1_if.req_cmd_valid = 1'b0; in1_if.req_cmd_bits_rw = 1'b0; cmd_done = 1'b1;
                in0_if.req_cmd_valid = 1'b1; in0_if.req_cmd_bits_rw = 1'b0;
                in0_if.req_cmd_bits_addr = 26'h170; in0_if.req_cmd_bits_tag = 5'h0B;
            end
            if (df) begin
                if (beats < int'(NB)) in1_if.req_data_bits_data = beat_val(1, beats);
                else in1_if.req_data_valid = 1'b0;
            end
            out_if.req_data_ready = ~out_if.req_data_ready;
            if (c0f) in0_if.req_cmd_valid = 1'b0;
        end
        check("write_beat_count", 160'(beats), 160'(NB));
        check("in0_fires_after_last_beat", 160'(r0_cyc), 160'(last_cyc + 1));
        in0_if.req_cmd_valid = 1'b0;
        in1_if.req_data_valid = 1'b0;
        out_if.req_data_ready = 1'b1;

        // Responses steered by tag MSB; requester 1 back-pressures the shared port.
        exp_r0.push_back('{tag: 5'h03, data: 128'hD0D0_0003});
        exp_r1.push_back('{tag: 5'h03, data: 128'hD1D1_0023});
        in0_if.resp_ready = 1'b1; in1_if.resp_ready = 1'b0;
        out_if.resp_valid = 1'b1; out_if.resp_bits_tag = 6'h03; out_if.resp_bits_data = 128'hD0D0_0003;
        @(negedge clk);
        check("resp0_ready", 160'(out_if.resp_ready), 160'(1));
        check("resp0_not_in1", 160'(in1_if.resp_valid), 160'(0));
        tick();
        out_if.resp_bits_tag = 6'h23; out_if.resp_bits_data = 128'hD1D1_0023;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("resp1_backpressure", 160'(out_if.resp_ready), 160'(0));
            check("resp1_valid", 160'({in1_if.resp_valid, in0_if.resp_valid}), 160'(2'b10));
            tick();
        end
        in1_if.resp_ready = 1'b1;
        @(negedge clk);
        check("resp1_release", 160'(out_if.resp_ready), 160'(1));
        tick();
        out_if.resp_valid = 1'b0;

        // Reset after two beats of a requester-0 write abandons the rest.
        exp_cmd.push_back('{rw: 1'b1, addr: 26'h1C0, tag: 6'h04});
        exp_data.push_back(beat_val(0, 0));
        exp_data.push_back(beat_val(0, 1));
        exp_cmd.push_back('{rw: 1'b0, addr: 26'h180, tag: 6'h05});
        in0_if.req_cmd_valid = 1'b1; in0_if.req_cmd_bits_rw = 1'b1;
        in0_if.req_cmd_bits_addr = 26'h1C0; in0_if.req_cmd_bits_tag = 5'h04;
        in0_if.req_data_valid = 1'b1; in0_if.req_data_bits_data = beat_val(0, 0);
        @(negedge clk);
        check("w0_cmd_ready", 160'(in0_if.req_cmd_ready), 160'(1));
        tick();
        in0_if.req_cmd_valid = 1'b0; in0_if.req_cmd_bits_rw = 1'b0;
        @(negedge clk);
        check("w0_beat0_ready", 160'(in0_if.req_data_ready), 160'(1));
        tick();
        in0_if.req_data_bits_data = beat_val(0, 1);
        @(negedge clk);
        check("w0_beat1_ready", 160'(in0_if.req_data_ready), 160'(1));
        tick();
        in0_if.req_data_bits_data = beat_val(0, 2);
        reset = 1'b1;
        out_if.resp_valid = 1'b1; out_if.resp_bits_tag = 6'h00;
        @(negedge clk);
        check("midwrite_reset_outputs",
              160'({out_if.req_data_valid, in0_if.req_data_ready, out_if.req_cmd_valid,
                    out_if.resp_ready, in0_if.resp_valid}), 160'(0));
        tick();
        reset = 1'b0;
        out_if.resp_valid = 1'b0;
        @(negedge clk);
        check("post_reset_idle_data",
              160'({out_if.req_data_valid, in0_if.req_data_ready}), 160'(0));
        tick();
        in0_if.req_cmd_valid = 1'b1; in0_if.req_cmd_bits_addr = 26'h180; in0_if.req_cmd_bits_tag = 5'h05;
        @(negedge clk);
        check("read_after_reset_ready", 160'(in0_if.req_cmd_ready), 160'(1));
        check("read_after_reset_no_data", 160'(out_if.req_data_valid), 160'(0));
        tick();
        in0_if.req_cmd_valid = 1'b0;
        in0_if.req_data_valid = 1'b0;

        repeat (3) tick();
        check("cmd_queue_drained",  160'(exp_cmd.size()),  160'(0));
        check("data_queue_drained", 160'(exp_data.size()), 160'(0));
        check("resp_queues_drained", 160'(exp_r0.size() + exp_r1.size()), 160'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
